// File: rtl/mmu_pkg.sv
// Shared MMU definitions: page-table-walk arbiter states, requester identities
// and the Sv32/Sv39 PTE permission bit positions.
package mmu_pkg;

    typedef enum logic [1:0] {
        PTW_IDLE  = 2'd0,
        PTW_ISSUE = 2'd1,
        PTW_WAIT  = 2'd2,
        PTW_RESP  = 2'd3
    } ptw_state_e;

    localparam logic OWNER_I = 1'b1;
    localparam logic OWNER_D = 1'b0;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;
    localparam int PTE_BITS = 8;

endpackage

// File: rtl/ptw_arbiter.sv
// Arbitrates I-TLB and D-TLB miss requests onto a single page-table walker,
// one walk at a time, and routes fills/responses back to the requesting TLB.
module ptw_arbiter
    import mmu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                itlb_req_valid,
    input  logic [XLEN-1:0]     itlb_req_vaddr,
    input  logic                dtlb_req_valid,
    input  logic [XLEN-1:0]     dtlb_req_vaddr,
    input  logic                dtlb_req_is_store,

    output logic                itlb_resp_ready,
    output logic                dtlb_resp_ready,
    output logic                itlb_resp_fault,
    output logic                dtlb_resp_fault,
    output logic                itlb_resp_retry,
    output logic                dtlb_resp_retry,
    output logic [XLEN-1:0]     resp_fault_vaddr,

    output logic                itlb_upd_valid,
    output logic                dtlb_upd_valid,
    output logic [XLEN-1:0]     upd_vpn,
    output logic [XLEN-1:0]     upd_ppn,
    output logic [XLEN-1:0]     upd_level,
    output logic [PTE_BITS-1:0] upd_pte,

    output logic                ptw_req_valid,
    output logic [XLEN-1:0]     ptw_req_vaddr,
    output logic                ptw_req_is_store,
    output logic                ptw_req_is_fetch,

    input  logic                ptw_req_ready,
    input  logic                ptw_req_page_fault,
    input  logic [XLEN-1:0]     ptw_req_fault_vaddr,
    input  logic                ptw_result_valid,
    input  logic [XLEN-1:0]     ptw_result_vpn,
    input  logic [XLEN-1:0]     ptw_result_ppn,
    input  logic [PTE_BITS-1:0] ptw_result_pte,
    input  logic [XLEN-1:0]     ptw_result_level,

    input  logic                flush
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    ptw_state_e    state_q;
    logic          owner_q;
    logic [XLEN-1:0] vaddr_q;
    logic          is_store_q;
    logic          is_fetch_q;
    logic          req_valid_q;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          cancel_q;
    logic          resp_i_q;
    logic          resp_d_q;
    logic          fault_q;
    logic          retry_q;
    logic [XLEN-1:0] fault_vaddr_q;

    logic          grant_owner;
    logic          walk_done;
    logic          cancel_now;
    logic          fill;

    // D-TLB has priority; the I-TLB wins only when alone or once it has
    // watched STARVE_MAX consecutive D grants go past it.
    function automatic logic pick_owner(input logic i_v, input logic d_v,
                                        input logic [SW-1:0] cnt);
        return (i_v && (!d_v || cnt == STARVE_TOP)) ? OWNER_I : OWNER_D;
    endfunction

    assign grant_owner = pick_owner(itlb_req_valid, dtlb_req_valid, starve_q);

    always_comb begin
        starve_d = '0;
        if (grant_owner == OWNER_D && itlb_req_valid) begin
            starve_d = (starve_q == STARVE_TOP) ? starve_q : starve_q + 1'b1;
        end
    end

    // A flush landing in the same cycle as walk completion still cancels it.
    assign walk_done  = (state_q == PTW_WAIT) && ptw_req_ready;
    assign cancel_now = cancel_q || flush;
    assign fill       = walk_done && ptw_result_valid && !cancel_now;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PTW_IDLE;
            owner_q       <= OWNER_D;
            vaddr_q       <= '0;
            is_store_q    <= 1'b0;
            is_fetch_q    <= 1'b0;
            req_valid_q   <= 1'b0;
            starve_q      <= '0;
            cancel_q      <= 1'b0;
            resp_i_q      <= 1'b0;
            resp_d_q      <= 1'b0;
            fault_q       <= 1'b0;
            retry_q       <= 1'b0;
            fault_vaddr_q <= '0;
        end else begin
            req_valid_q   <= 1'b0;
            resp_i_q      <= 1'b0;
            resp_d_q      <= 1'b0;
            fault_q       <= 1'b0;
            retry_q       <= 1'b0;
            fault_vaddr_q <= '0;
            case (state_q)
                PTW_IDLE: begin
                    if (itlb_req_valid || dtlb_req_valid) begin
                        owner_q     <= grant_owner;
                        vaddr_q     <= (grant_owner == OWNER_I) ? itlb_req_vaddr : dtlb_req_vaddr;
                        is_store_q  <= (grant_owner == OWNER_D) && dtlb_req_is_store;
                        is_fetch_q  <= (grant_owner == OWNER_I);
                        starve_q    <= starve_d;
                        req_valid_q <= 1'b1;
                        state_q     <= PTW_ISSUE;
                    end
                end
                PTW_ISSUE: begin
                    if (flush) begin
                        cancel_q <= 1'b1;
                    end
                    state_q <= PTW_WAIT;
                end
                PTW_WAIT: begin
                    if (flush) begin
                        cancel_q <= 1'b1;
                    end
                    if (ptw_req_ready) begin
                        resp_i_q      <= (owner_q == OWNER_I);
                        resp_d_q      <= (owner_q == OWNER_D);
                        fault_q       <= ptw_req_page_fault && !cancel_now;
                        retry_q       <= cancel_now;
                        fault_vaddr_q <= (ptw_req_page_fault && !cancel_now) ? ptw_req_fault_vaddr : '0;
                        state_q       <= PTW_RESP;
                    end
                end
                PTW_RESP: begin
                    cancel_q <= 1'b0;
                    state_q  <= PTW_IDLE;
                end
                default: state_q <= PTW_IDLE;
            endcase
        end
    end

    assign ptw_req_valid    = req_valid_q;
    assign ptw_req_vaddr    = vaddr_q;
    assign ptw_req_is_store = is_store_q;
    assign ptw_req_is_fetch = is_fetch_q;

    assign itlb_resp_ready  = resp_i_q;
    assign dtlb_resp_ready  = resp_d_q;
    assign itlb_resp_fault  = resp_i_q && fault_q;
    assign dtlb_resp_fault  = resp_d_q && fault_q;
    assign itlb_resp_retry  = resp_i_q && retry_q;
    assign dtlb_resp_retry  = resp_d_q && retry_q;
    assign resp_fault_vaddr = fault_vaddr_q;

    assign itlb_upd_valid   = fill && (owner_q == OWNER_I);
    assign dtlb_upd_valid   = fill && (owner_q == OWNER_D);
    assign upd_vpn          = fill ? ptw_result_vpn   : '0;
    assign upd_ppn          = fill ? ptw_result_ppn   : '0;
    assign upd_level        = fill ? ptw_result_level : '0;
    assign upd_pte          = fill ? ptw_result_pte   : '0;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Scoreboard bench for ptw_arbiter: a small walker model answers each issued
// walk; expected issues/responses are queued when requests are raised.
module tb_ptw_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        itlb_req_valid = 1'b0, dtlb_req_valid = 1'b0, dtlb_req_is_store = 1'b0;
    logic [31:0] itlb_req_vaddr = '0, dtlb_req_vaddr = '0;
    logic        itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, dtlb_resp_fault;
    logic        itlb_resp_retry, dtlb_resp_retry, itlb_upd_valid, dtlb_upd_valid;
    logic [31:0] resp_fault_vaddr, upd_vpn, upd_ppn, upd_level, ptw_req_vaddr;
    logic [7:0]  upd_pte;
    logic        ptw_req_valid, ptw_req_is_store, ptw_req_is_fetch;
    logic        ptw_req_ready = 1'b0, ptw_req_page_fault = 1'b0, ptw_result_valid = 1'b0;
    logic [31:0] ptw_req_fault_vaddr = '0, ptw_result_vpn = '0, ptw_result_ppn = '0, ptw_result_level = '0;
    logic [7:0]  ptw_result_pte = '0;
    logic        flush = 1'b0;

    ptw_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .itlb_req_valid(itlb_req_valid), .itlb_req_vaddr(itlb_req_vaddr),
        .dtlb_req_valid(dtlb_req_valid), .dtlb_req_vaddr(dtlb_req_vaddr),
        .dtlb_req_is_store(dtlb_req_is_store),
        .itlb_resp_ready(itlb_resp_ready), .dtlb_resp_ready(dtlb_resp_ready),
        .itlb_resp_fault(itlb_resp_fault), .dtlb_resp_fault(dtlb_resp_fault),
        .itlb_resp_retry(itlb_resp_retry), .dtlb_resp_retry(dtlb_resp_retry),
        .resp_fault_vaddr(resp_fault_vaddr),
        .itlb_upd_valid(itlb_upd_valid), .dtlb_upd_valid(dtlb_upd_valid),
        .upd_vpn(upd_vpn), .upd_ppn(upd_ppn), .upd_level(upd_level), .upd_pte(upd_pte),
        .ptw_req_valid(ptw_req_valid), .ptw_req_vaddr(ptw_req_vaddr),
        .ptw_req_is_store(ptw_req_is_store), .ptw_req_is_fetch(ptw_req_is_fetch),
        .ptw_req_ready(ptw_req_ready), .ptw_req_page_fault(ptw_req_page_fault),
        .ptw_req_fault_vaddr(ptw_req_fault_vaddr), .ptw_result_valid(ptw_result_valid),
        .ptw_result_vpn(ptw_result_vpn), .ptw_result_ppn(ptw_result_ppn),
        .ptw_result_pte(ptw_result_pte), .ptw_result_level(ptw_result_level),
        .flush(flush)
    );

    always #5 clk = ~clk;

    logic [178:0] all_out;
    assign all_out = {itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, dtlb_resp_fault,
                      itlb_resp_retry, dtlb_resp_retry, resp_fault_vaddr, itlb_upd_valid,
                      dtlb_upd_valid, upd_vpn, upd_ppn, upd_level, upd_pte, ptw_req_valid,
                      ptw_req_vaddr, ptw_req_is_store, ptw_req_is_fetch};

    typedef struct { logic is_i; logic [31:0] va; logic st; } iss_t;
    typedef struct { logic is_i; logic fault; logic retry; logic [31:0] fva; } rsp_t;
    iss_t iss_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int w_lat = 1, w_cnt = 0;
    logic w_fault = 1'b0, w_rvalid = 1'b0, i_keep = 1'b0, d_keep = 1'b0;
    logic [31:0] w_fva = '0, w_vpn = '0, w_ppn = '0, w_level = '0;
    logic [7:0]  w_pte = '0;

    // Advance to just after the next rising edge and drive this cycle's inputs:
    // requesters drop on their response, the walker answers w_lat cycles after issue.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        flush = 1'b0;
        if (itlb_resp_ready && !i_keep) itlb_req_valid = 1'b0;
        if (dtlb_resp_ready && !d_keep) dtlb_req_valid = 1'b0;
        ptw_req_ready = 1'b0; ptw_req_page_fault = 1'b0; ptw_req_fault_vaddr = '0;
        ptw_result_valid = 1'b0; ptw_result_vpn = '0; ptw_result_ppn = '0;
        ptw_result_pte = '0; ptw_result_level = '0;
        if (!reset_n) w_cnt = 0;
        else if (ptw_req_valid) w_cnt = w_lat;
        else if (w_cnt > 0) begin
            w_cnt--;
            if (w_cnt == 0) begin
                ptw_req_ready = 1'b1; ptw_req_page_fault = w_fault; ptw_req_fault_vaddr = w_fva;
                ptw_result_valid = w_rvalid; ptw_result_vpn = w_vpn; ptw_result_ppn = w_ppn;
                ptw_result_pte = w_pte; ptw_result_level = w_level;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        dtlb_req_vaddr = 32'h8000_0000;
        dtlb_req_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (all_out !== '0) begin n_bad++; $display("FAIL reset_hold: outputs=%h want 0", all_out); end
        end
        dtlb_req_valid = 1'b0;
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if (all_out !== '0) begin n_bad++; $display("FAIL reset_idle: outputs=%h want 0", all_out); end
        end
    endtask

    // Simultaneous requests: D first, I back-to-back after D's response.
    task automatic test_simul();
        int gcyc, d_resp = -1, i_iss = -1;
        iss_t ei; rsp_t er;
        tick();
        w_lat = 2; w_rvalid = 1'b0; w_fault = 1'b0;
        itlb_req_vaddr = 32'h0040_0000; dtlb_req_vaddr = 32'h8000_1000; dtlb_req_is_store = 1'b0;
        itlb_req_valid = 1'b1; dtlb_req_valid = 1'b1; gcyc = cyc;
        iss_q.push_back('{1'b0, 32'h8000_1000, 1'b0}); iss_q.push_back('{1'b1, 32'h0040_0000, 1'b0});
        rsp_q.push_back('{1'b0, 1'b0, 1'b0, 32'h0}); rsp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0});
        for (int n = 0; n < 40 && (iss_q.size() != 0 || rsp_q.size() != 0); n++) begin
            @(negedge clk);
            if (ptw_req_valid && iss_q.size() != 0) begin
                ei = iss_q.pop_front();
                n_cmp++;
                if ({ptw_req_is_fetch, ptw_req_is_store, ptw_req_vaddr} !== {ei.is_i, ei.st, ei.va}) begin
                    n_bad++;
                    $display("FAIL simul_issue: fetch=%0b store=%0b va=%h want fetch=%0b store=%0b va=%h",
                             ptw_req_is_fetch, ptw_req_is_store, ptw_req_vaddr, ei.is_i, ei.st, ei.va);
                end
                if (ei.is_i) i_iss = cyc;
            end
            if ((itlb_resp_ready || dtlb_resp_ready) && rsp_q.size() != 0) begin
                er = rsp_q.pop_front();
                n_cmp++;
                if ({itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, dtlb_resp_fault, itlb_resp_retry, dtlb_resp_retry}
                    !== {er.is_i, !er.is_i, 4'b0000}) begin
                    n_bad++;
                    $display("FAIL simul_resp: i_rdy=%0b d_rdy=%0b flt=%0b%0b rty=%0b%0b want owner_i=%0b clean",
                             itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, dtlb_resp_fault,
                             itlb_resp_retry, dtlb_resp_retry, er.is_i);
                end
                if (!er.is_i) d_resp = cyc;
            end
            tick();
        end
        n_cmp++;
        if (iss_q.size() != 0 || rsp_q.size() != 0) begin
            n_bad++; $display("FAIL simul_timeout: pending iss=%0d rsp=%0d want 0", iss_q.size(), rsp_q.size());
        end
        iss_q.delete(); rsp_q.delete();
        // Grant cycle through response cycle inclusive = walker WAIT cycles + 3.
        n_cmp++;
        if (d_resp - gcyc + 1 != w_lat + 3) begin
            n_bad++; $display("FAIL simul_latency: got %0d cycles want %0d", d_resp - gcyc + 1, w_lat + 3);
        end
        n_cmp++;
        if (i_iss != d_resp + 2) begin
            n_bad++; $display("FAIL simul_back_to_back: i issue cycle %0d want %0d", i_iss, d_resp + 2);
        end
    endtask

    // D held continuously with I pending: grants D,D,D,D then I.
    task automatic test_starve();
        int i_cnt = 0;
        rsp_t er;
        tick();
        w_lat = 1; w_rvalid = 1'b0; w_fault = 1'b0; d_keep = 1'b1;
        dtlb_req_vaddr = 32'h8000_2000; itlb_req_vaddr = 32'h0040_1000;
        dtlb_req_valid = 1'b1; itlb_req_valid = 1'b1;
        repeat (4) rsp_q.push_back('{1'b0, 1'b0, 1'b0, 32'h0});
        rsp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0});
        for (int n = 0; n < 60 && rsp_q.size() != 0; n++) begin
            @(negedge clk);
            if (itlb_resp_ready) i_cnt++;
            if ((itlb_resp_ready || dtlb_resp_ready) && rsp_q.size() != 0) begin
                er = rsp_q.pop_front();
                n_cmp++;
                if ({itlb_resp_ready, dtlb_resp_ready} !== {er.is_i, !er.is_i}) begin
                    n_bad++;
                    $display("FAIL starve_order: i_rdy=%0b d_rdy=%0b want owner_i=%0b (remaining %0d)",
                             itlb_resp_ready, dtlb_resp_ready, er.is_i, rsp_q.size());
                end
                if (er.is_i) begin d_keep = 1'b0; dtlb_req_valid = 1'b0; end
            end
            tick();
        end
        repeat (6) begin
            @(negedge clk);
            if (itlb_resp_ready) i_cnt++;
            tick();
        end
        n_cmp++;
        if (rsp_q.size() != 0 || i_cnt != 1) begin
            n_bad++; $display("FAIL starve_i_once: i pulses=%0d pending=%0d want 1 and 0", i_cnt, rsp_q.size());
        end
        rsp_q.delete(); d_keep = 1'b0; dtlb_req_valid = 1'b0;
    endtask

    // I walk with a result: fill steered to I-TLB in the walker-ready cycle.
    task automatic test_fill();
        int n_upd = 0;
        rsp_t er;
        tick();
        w_lat = 3; w_rvalid = 1'b1; w_fault = 1'b0;
        w_ppn = 32'h0001_2345; w_vpn = 32'h0000_0400; w_level = 32'd0; w_pte = 8'hCF;
        itlb_req_vaddr = 32'h0040_0000; itlb_req_valid = 1'b1;
        rsp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0});
        for (int n = 0; n < 30 && rsp_q.size() != 0; n++) begin
            @(negedge clk);
            if (itlb_upd_valid || dtlb_upd_valid) begin
                n_upd++;
                n_cmp++;
                if ({itlb_upd_valid, dtlb_upd_valid, upd_ppn, upd_vpn, upd_level, upd_pte}
                    !== {1'b1, 1'b0, 32'h0001_2345, 32'h0000_0400, 32'd0, 8'hCF}) begin
                    n_bad++;
                    $display("FAIL fill_data: i_upd=%0b d_upd=%0b ppn=%h vpn=%h lvl=%h pte=%h want 1 0 00012345 00000400 0 cf",
                             itlb_upd_valid, dtlb_upd_valid, upd_ppn, upd_vpn, upd_level, upd_pte);
                end
            end
            if ((itlb_resp_ready || dtlb_resp_ready) && rsp_q.size() != 0) begin
                er = rsp_q.pop_front();
                n_cmp++;
                if ({itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, itlb_resp_retry} !== {er.is_i, !er.is_i, 2'b00}) begin
                    n_bad++;
                    $display("FAIL fill_resp: i_rdy=%0b d_rdy=%0b flt=%0b rty=%0b want 1 0 0 0",
                             itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, itlb_resp_retry);
                end
            end
            tick();
        end
        n_cmp++;
        if (rsp_q.size() != 0 || n_upd != 1) begin
            n_bad++; $display("FAIL fill_count: upd pulses=%0d pending=%0d want 1 and 0", n_upd, rsp_q.size());
        end
        rsp_q.delete(); w_rvalid = 1'b0;
    endtask

    // D store walk that faults.
    task automatic test_fault();
        rsp_t er; iss_t ei;
        tick();
        w_lat = 2; w_rvalid = 1'b0; w_fault = 1'b1; w_fva = 32'hC000_0004;
        dtlb_req_vaddr = 32'hC000_0004; dtlb_req_is_store = 1'b1; dtlb_req_valid = 1'b1;
        iss_q.push_back('{1'b0, 32'hC000_0004, 1'b1});
        rsp_q.push_back('{1'b0, 1'b1, 1'b0, 32'hC000_0004});
        for (int n = 0; n < 30 && (iss_q.size() != 0 || rsp_q.size() != 0); n++) begin
            @(negedge clk);
            if (ptw_req_valid && iss_q.size() != 0) begin
                ei = iss_q.pop_front();
                n_cmp++;
                if ({ptw_req_is_fetch, ptw_req_is_store, ptw_req_vaddr} !== {ei.is_i, ei.st, ei.va}) begin
                    n_bad++;
                    $display("FAIL fault_issue: fetch=%0b store=%0b va=%h want fetch=%0b store=%0b va=%h",
                             ptw_req_is_fetch, ptw_req_is_store, ptw_req_vaddr, ei.is_i, ei.st, ei.va);
                end
            end
            if ((itlb_resp_ready || dtlb_resp_ready) && rsp_q.size() != 0) begin
                er = rsp_q.pop_front();
                n_cmp++;
                if ({itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, dtlb_resp_fault, dtlb_resp_retry, resp_fault_vaddr}
                    !== {1'b0, 1'b1, 1'b0, er.fault, er.retry, er.fva}) begin
                    n_bad++;
                    $display("FAIL fault_resp: i_rdy=%0b d_rdy=%0b i_flt=%0b d_flt=%0b rty=%0b fva=%h want 0 1 0 1 0 %h",
                             itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, dtlb_resp_fault,
                             dtlb_resp_retry, resp_fault_vaddr, er.fva);
                end
            end
            tick();
        end
        n_cmp++;
        if (iss_q.size() != 0 || rsp_q.size() != 0) begin
            n_bad++; $display("FAIL fault_timeout: pending iss=%0d rsp=%0d want 0", iss_q.size(), rsp_q.size());
        end
        iss_q.delete(); rsp_q.delete(); w_fault = 1'b0; dtlb_req_is_store = 1'b0;
    endtask

    // Walk 0: flush in the IDLE grant cycle (ignored). Walk 1: flush two cycles into WAIT.
    task automatic test_flush();
        rsp_t er;
        for (int w = 0; w < 2; w++) begin
            int n_upd = 0, c = -1;
            tick();
            w_lat = (w == 0) ? 3 : 5; w_rvalid = 1'b1; w_fault = (w == 1);
            w_fva = 32'h8000_3000; w_ppn = 32'h0000_0777; w_vpn = 32'h0008_0003; w_pte = 8'h0F;
            dtlb_req_vaddr = 32'h8000_3000; dtlb_req_valid = 1'b1;
            if (w == 0) flush = 1'b1;
            rsp_q.push_back('{1'b0, 1'b0, w == 1, 32'h0});
            for (int n = 0; n < 30 && rsp_q.size() != 0; n++) begin
                @(negedge clk);
                if (ptw_req_valid) c = cyc;
                if (itlb_upd_valid || dtlb_upd_valid) n_upd++;
                if ((itlb_resp_ready || dtlb_resp_ready) && rsp_q.size() != 0) begin
                    er = rsp_q.pop_front();
                    n_cmp++;
                    if ({itlb_resp_ready, dtlb_resp_ready, dtlb_resp_fault, dtlb_resp_retry, itlb_resp_retry}
                        !== {1'b0, 1'b1, er.fault, er.retry, 1'b0}) begin
                        n_bad++;
                        $display("FAIL flush_resp%0d: i_rdy=%0b d_rdy=%0b flt=%0b rty=%0b want 0 1 %0b %0b",
                                 w, itlb_resp_ready, dtlb_resp_ready, dtlb_resp_fault, dtlb_resp_retry,
                                 er.fault, er.retry);
                    end
                end
                tick();
                if (w == 1 && c >= 0 && cyc == c + 2) flush = 1'b1;
            end
            n_cmp++;
            if (rsp_q.size() != 0 || n_upd != ((w == 0) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL flush_upd%0d: upd pulses=%0d pending=%0d want %0d and 0",
                         w, n_upd, rsp_q.size(), (w == 0) ? 1 : 0);
            end
            rsp_q.delete();
        end
        w_fault = 1'b0; w_rvalid = 1'b0;
    endtask

    // Reset asserted mid-WAIT: outputs clear at once, no late response, next walk works.
    task automatic test_reset_mid();
        int c = -1, stray = 0;
        rsp_t er;
        tick();
        w_lat = 8; w_rvalid = 1'b0; w_fault = 1'b0;
        dtlb_req_vaddr = 32'h8000_4000; dtlb_req_valid = 1'b1;
        for (int n = 0; n < 20 && c < 0; n++) begin
            @(negedge clk);
            if (ptw_req_valid) c = cyc;
            tick();
        end
        for (int n = 0; n < 10 && c >= 0 && cyc < c + 3; n++) tick();
        reset_n = 1'b0;
        dtlb_req_valid = 1'b0;
        #1;
        n_cmp++;
        if (c < 0 || all_out !== '0) begin
            n_bad++; $display("FAIL reset_mid_async: issue_cycle=%0d outputs=%h want issued and 0", c, all_out);
        end
        tick(); tick();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) begin
            tick();
            @(negedge clk);
            if (itlb_resp_ready || dtlb_resp_ready || ptw_req_valid) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_bad++; $display("FAIL reset_mid_stray: activity cycles=%0d want 0", stray); end
        tick();
        w_lat = 2;
        itlb_req_vaddr = 32'h0040_2000; itlb_req_valid = 1'b1;
        rsp_q.push_back('{1'b1, 1'b0, 1'b0, 32'h0});
        for (int n = 0; n < 30 && rsp_q.size() != 0; n++) begin
            @(negedge clk);
            if ((itlb_resp_ready || dtlb_resp_ready) && rsp_q.size() != 0) begin
                er = rsp_q.pop_front();
                n_cmp++;
                if ({itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, itlb_resp_retry} !== {er.is_i, !er.is_i, 2'b00}) begin
                    n_bad++;
                    $display("FAIL reset_mid_next: i_rdy=%0b d_rdy=%0b flt=%0b rty=%0b want 1 0 0 0",
                             itlb_resp_ready, dtlb_resp_ready, itlb_resp_fault, itlb_resp_retry);
                end
            end
            tick();
        end
        n_cmp++;
        if (rsp_q.size() != 0) begin n_bad++; $display("FAIL reset_mid_timeout: pending=%0d want 0", rsp_q.size()); end
        rsp_q.delete();
    endtask

    initial begin
        test_reset();
        test_simul();
        test_starve();
        test_fill();
        test_fault();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
